hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks the micro-instructions that have left decode and stalls decode when
// the instruction there would read a resource (W, CY, or a register) that a
// tracked instruction still has to write. It also reports a branch reaching
// stage BR_STAGE, the number of occupied stages, and a saturating count of
// stall cycles.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   dec_valid       micro-instruction present in decode
//   dec_a           source register index read by decode
//   dec_c           destination tag of decode (low REG_AW bits compared)
//   dec_t           T flags: [0] rd W, [1] wr W, [2] rd Rj, [3] wr Ri,
//                   [4] rd CY, [5] wr CY, [6] wr PC
//   advance         pipeline enable, 0 freezes the tracked stages
//   flush           drop every tracked entry
//   hold            stall decode this cycle (combinational)
//   branch_update   branch occupies stage BR_STAGE (combinational from state)
//   pending         number of valid tracked entries
//   stall_cnt       saturating count of cycles with hold=1
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned BR_STAGE = 1,
  parameter int unsigned SC_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [REG_AW-1:0]            dec_a,
  input  logic [REG_AW:0]              dec_c,
  input  logic [6:0]                   dec_t,
  input  logic                         advance,
  input  logic                         flush,
  output logic                         hold,
  output logic                         branch_update,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [SC_W-1:0]              stall_cnt
);

  localparam int unsigned CW = REG_AW + 1;
  localparam int unsigned TW = 7;
  localparam int unsigned PW = $clog2(DEPTH + 1);

  localparam logic [TW-1:0] BR_T_A = 7'b1000001;
  localparam logic [TW-1:0] BR_T_B = 7'b1010000;

  // Entry 0 is the youngest; entry DEPTH-1 retires on the next advance.
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_c [DEPTH];
  logic [TW-1:0]    r_t [DEPTH];
  logic [SC_W-1:0]  r_stall_cnt;

  logic             w_hit;
  logic [PW-1:0]    w_pending;
  logic [DEPTH-1:0] w_unused_ctag;

  // Hazard search: decode only compares against tracked entries, so an
  // instruction that reads and writes the same resource never blocks itself.
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (r_valid[k]) begin
        if ((dec_t[0] && r_t[k][1]) ||
            (dec_t[4] && r_t[k][5]) ||
            (dec_t[2] && r_t[k][3] && (dec_a == r_c[k][REG_AW-1:0]))) begin
          w_hit = 1'b1;
        end
      end
    end
  end

  assign hold = dec_valid & w_hit;

  // Population count of the occupied stages.
  always_comb begin
    w_pending = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_pending = w_pending + PW'(r_valid[k]);
    end
  end

  assign pending = w_pending;

  assign branch_update = r_valid[BR_STAGE] &&
                         ((r_t[BR_STAGE] == BR_T_A) || (r_t[BR_STAGE] == BR_T_B));

  // The tag's top bit is carried with the entry but never compared.
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_unused_ctag[k] = r_c[k][REG_AW];
    end
  end

  // Tracked stages: flush beats advance; a held decode enters as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_c[k] <= '0;
        r_t[k] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (advance) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_c[k]     <= r_c[k-1];
        r_t[k]     <= r_t[k-1];
      end
      r_valid[0] <= dec_valid & ~w_hit;
      r_c[0]     <= dec_c;
      r_t[0]     <= dec_t;
    end
  end

  // Stall counter counts every held cycle, frozen or not, and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (hold && (r_stall_cnt != {SC_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + SC_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a list-of-instructions model
// predicts every output each cycle; directed sequences pin the model with
// hand-computed values, then randomized traffic runs against the model.
module tb_hazard_scoreboard;

  localparam int unsigned D = 3;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_a;
  logic [5:0]  dec_c;
  logic [6:0]  dec_t;
  logic        advance;
  logic        flush;

  logic        hold, br;
  logic [1:0]  pend;
  logic [15:0] sc;
  logic        hold_s, br_s;
  logic [1:0]  pend_s;
  logic [1:0]  sc_s;

  int n_vec;
  int n_err;

  hazard_scoreboard u_dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_a(dec_a),
    .dec_c(dec_c), .dec_t(dec_t), .advance(advance), .flush(flush),
    .hold(hold), .branch_update(br), .pending(pend), .stall_cnt(sc)
  );

  hazard_scoreboard #(.SC_W(2)) u_sat (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_a(dec_a),
    .dec_c(dec_c), .dec_t(dec_t), .advance(advance), .flush(flush),
    .hold(hold_s), .branch_update(br_s), .pending(pend_s), .stall_cnt(sc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: instructions in flight, index 0 youngest, plus a plain stall tally.
  typedef struct {
    bit         v;
    logic [5:0] c;
    logic [6:0] t;
  } ent_t;

  ent_t m [D];
  int   m_cnt;

  localparam logic [6:0] T_WR_R = 7'b0001000;
  localparam logic [6:0] T_RD_R = 7'b0000100;

  function automatic bit writes_what_i_read(input ent_t e);
    bit r;
    r = 1'b0;
    if (dec_t[0] && e.t[1]) r = 1'b1;                              // W
    if (dec_t[4] && e.t[5]) r = 1'b1;                              // CY
    if (dec_t[2] && e.t[3] && (e.c[4:0] == dec_a)) r = 1'b1;       // register
    return r;
  endfunction

  function automatic bit exp_hold();
    if (dec_valid !== 1'b1) return 1'b0;
    foreach (m[k]) if (m[k].v && writes_what_i_read(m[k])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_pend();
    int n;
    n = 0;
    foreach (m[k]) n += int'(m[k].v);
    return n;
  endfunction

  function automatic bit exp_br();
    return m[1].v && (m[1].t == 7'b1000001 || m[1].t == 7'b1010000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m[k]) begin
      m[k].v = 1'b0;
      m[k].c = '0;
      m[k].t = '0;
    end
    m_cnt = 0;
  endtask

  task automatic compare_all();
    int cs;
    cs = (m_cnt > 3) ? 3 : m_cnt;
    chk("hold",        32'(hold),   32'(exp_hold()));
    chk("branch",      32'(br),     32'(exp_br()));
    chk("pending",     32'(pend),   32'(exp_pend()));
    chk("stall_cnt",   32'(sc),     32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("hold_sat",    32'(hold_s), 32'(exp_hold()));
    chk("branch_sat",  32'(br_s),   32'(exp_br()));
    chk("pending_sat", 32'(pend_s), 32'(exp_pend()));
    chk("stall_sat",   32'(sc_s),   32'(cs));
  endtask

  // Apply one set of inputs between edges and compare against the model.
  task automatic drive(input bit r, input bit v, input logic [4:0] a,
                       input logic [5:0] c, input logic [6:0] t,
                       input bit adv, input bit fl);
    rst       = r;
    dec_valid = v;
    dec_a     = a;
    dec_c     = c;
    dec_t     = t;
    advance   = adv;
    flush     = fl;
    if (r) model_clear();
    #2;
    compare_all();
  endtask

  // One rising edge, with the model stepped by the same rules.
  task automatic tick();
    bit h;
    h = exp_hold();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (h && m_cnt < 65535) m_cnt++;
      if (flush) begin
        foreach (m[k]) m[k].v = 1'b0;
      end else if (advance) begin
        for (int k = D - 1; k >= 1; k--) m[k] = m[k-1];
        m[0].v = dec_valid && !h;
        m[0].c = dec_c;
        m[0].t = dec_t;
      end
    end
    #1;
  endtask

  task automatic reset_seq();
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();
  endtask

  int exp_p [4] = '{1, 1, 1, 0};
  int exp_s [6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();

    // Reset state.
    reset_seq();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("rst_pending", 32'(pend), 32'd0);
    chk("rst_stall",   32'(sc),   32'd0);
    tick();

    // RAW on a register: three stalled cycles then clear.
    reset_seq();
    drive(1'b0, 1'b1, 5'h00, 6'h05, T_WR_R, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 5'h05, 6'h00, T_RD_R, 1'b1, 1'b0);
      chk("raw_hold", 32'(hold), 32'd1);
      tick();
    end
    drive(1'b0, 1'b1, 5'h05, 6'h00, T_RD_R, 1'b1, 1'b0);
    chk("raw_clear", 32'(hold), 32'd0);
    chk("raw_cnt",   32'(sc),   32'd3);
    tick();

    // Different register, top tag bit ignored: no hazard.
    reset_seq();
    drive(1'b0, 1'b1, 5'h00, 6'h25, T_WR_R, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 5'h06, 6'h00, T_RD_R, 1'b0, 1'b0);
    chk("nofalse_hold", 32'(hold), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("nofalse_pend", 32'(pend), 32'(exp_p[i]));
      tick();
    end

    // W and CY hazards.
    reset_seq();
    drive(1'b0, 1'b1, 5'h00, 6'h00, 7'b0100010, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 5'h00, 6'h00, 7'b0000001, 1'b0, 1'b0);
    chk("w_hold", 32'(hold), 32'd1);
    drive(1'b0, 1'b1, 5'h00, 6'h00, 7'b0010000, 1'b0, 1'b0);
    chk("cy_hold", 32'(hold), 32'd1);
    drive(1'b0, 1'b1, 5'h00, 6'h00, 7'b0000000, 1'b0, 1'b0);
    chk("none_hold", 32'(hold), 32'd0);
    tick();

    // Branch notify in stage 1, then flush.
    reset_seq();
    drive(1'b0, 1'b1, 5'h00, 6'h00, 7'b1000001, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("br_stage0", 32'(br), 32'd0);
    tick();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("br_stage1", 32'(br), 32'd1);
    tick();
    drive(1'b0, 1'b1, 5'h00, 6'h00, 7'b0111111, 1'b1, 1'b0);
    chk("flush_pend", 32'(pend), 32'd0);
    chk("flush_hold", 32'(hold), 32'd0);
    tick();

    // Frozen persistent hazard saturates the 2-bit counter.
    reset_seq();
    drive(1'b0, 1'b1, 5'h00, 6'h05, T_WR_R, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 5'h05, 6'h00, T_RD_R, 1'b0, 1'b0);
      tick();
      chk("sat_cnt",     32'(sc_s), 32'(exp_s[i]));
      chk("frozen_pend", 32'(pend), 32'd1);
    end

    // Asynchronous reset in the middle of that stall.
    drive(1'b0, 1'b1, 5'h05, 6'h00, T_RD_R, 1'b0, 1'b0);
    chk("pre_rst_hold", 32'(hold), 32'd1);
    drive(1'b1, 1'b1, 5'h05, 6'h00, T_RD_R, 1'b0, 1'b0);
    chk("arst_hold", 32'(hold), 32'd0);
    chk("arst_pend", 32'(pend), 32'd0);
    chk("arst_cnt",  32'(sc),   32'd0);
    chk("arst_sat",  32'(sc_s), 32'd0);
    tick();
    drive(1'b0, 1'b1, 5'h05, 6'h00, T_RD_R, 1'b1, 1'b0);
    chk("post_rst_hold", 32'(hold), 32'd0);
    tick();
    chk("post_rst_pend", 32'(pend), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit         r, v, adv, fl;
      logic [4:0] a;
      logic [5:0] c;
      logic [6:0] t;
      r   = ($urandom_range(0, 99) < 2);
      v   = ($urandom_range(0, 99) < 75);
      adv = ($urandom_range(0, 99) < 80);
      fl  = ($urandom_range(0, 99) < 5);
      a   = 5'($urandom_range(0, 3));
      c   = 6'($urandom) & 6'h23;
      t   = 7'($urandom);
      if ($urandom_range(0, 7) == 0) t = ($urandom_range(0, 1) == 0) ? 7'b1000001 : 7'b1010000;
      drive(r, v, a, c, t, adv, fl);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
